// File: rtl/ttl_74169_sync.sv
`default_nettype none
// ============================================================================
// Module   : ttl_74169_sync
// Brief    : LS169-style synchronous up/down binary counter with parallel load,
//            advanced by rising edges of the Cen strobe on the system clock.
// Revision : 1.0
// ============================================================================
module ttl_74169_sync #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Cen,
  input  logic             Load_bar,
  input  logic             ENP_bar,
  input  logic             ENT_bar,
  input  logic             U_D,
  input  logic [WIDTH-1:0] D,
  output logic             RCO_bar,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_ones = '1;
  localparam logic [WIDTH-1:0] c_zero = '0;

  logic             r_last_cen;
  logic [WIDTH-1:0] r_q;
  logic             w_trigger;
  logic             w_count_en;
  logic             w_terminal;

  // last_cen resets high so a Cen held through reset release is not an edge.
  assign w_trigger  = Cen & ~r_last_cen;
  assign w_count_en = ~ENP_bar & ~ENT_bar;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q        <= c_zero;
      r_last_cen <= 1'b1;
    end else begin
      r_last_cen <= Cen;
      if (w_trigger) begin
        if (!Load_bar) begin
          r_q <= D;
        end else if (w_count_en) begin
          r_q <= U_D ? (r_q + c_one) : (r_q - c_one);
        end
      end
    end
  end

  // Terminal count depends on direction: all-ones going up, zero going down.
  assign w_terminal = U_D ? (r_q == c_ones) : (r_q == c_zero);
  assign RCO_bar    = ~(~ENT_bar & w_terminal);
  assign Q          = r_q;

endmodule
`default_nettype wire

// File: tb/tb_ttl_74169_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttl_74169_sync
// Brief    : Vector table plus scoreboard bench for ttl_74169_sync, including a
//            two-stage cascade.
// Revision : 1.0
// ============================================================================
module tb_ttl_74169_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       cen;
  logic       load_bar, enp_bar, ent_bar, u_d;
  logic [3:0] d;
  logic       rco_bar;
  logic [3:0] q;

  logic       c_load_bar, c_enp_bar, c_ent_bar, c_u_d;
  logic [7:0] c_d;
  logic       lo_rco_bar, hi_rco_bar;
  logic [3:0] lo_q, hi_q;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       load_bar, enp_bar, ent_bar, u_d;
    logic [3:0] d;
    logic [3:0] exp_q;
    logic       exp_rco;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  ttl_74169_sync #(.WIDTH(4)) dut (
    .Clk(clk), .Reset(reset), .Cen(cen), .Load_bar(load_bar),
    .ENP_bar(enp_bar), .ENT_bar(ent_bar), .U_D(u_d), .D(d),
    .RCO_bar(rco_bar), .Q(q)
  );

  ttl_74169_sync #(.WIDTH(4)) u_lo (
    .Clk(clk), .Reset(reset), .Cen(cen), .Load_bar(c_load_bar),
    .ENP_bar(c_enp_bar), .ENT_bar(c_ent_bar), .U_D(c_u_d), .D(c_d[3:0]),
    .RCO_bar(lo_rco_bar), .Q(lo_q)
  );

  ttl_74169_sync #(.WIDTH(4)) u_hi (
    .Clk(clk), .Reset(reset), .Cen(cen), .Load_bar(c_load_bar),
    .ENP_bar(c_enp_bar), .ENT_bar(lo_rco_bar), .U_D(c_u_d), .D(c_d[7:4]),
    .RCO_bar(hi_rco_bar), .Q(hi_q)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_val(input string name, input int sel, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // sel 0: Q, 1: RCO_bar, 2: cascaded {hi,lo}
  task automatic drain();
    sb_t        e;
    logic [7:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = {4'h0, q};
        1:       act = {7'h0, rco_bar};
        default: act = {hi_q, lo_q};
      endcase
      check(e.name, act, e.exp);
    end
  endtask

  // One Cen rising edge; returns 1 time unit after the triggering posedge.
  task automatic pulse();
    @(negedge clk) cen = 1'b0;
    @(negedge clk) cen = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic set_in(input logic lb, input logic ep, input logic et,
                        input logic ud, input logic [3:0] dv);
    load_bar = lb; enp_bar = ep; ent_bar = et; u_d = ud; d = dv;
  endtask

  initial begin
    //            ld    enp   ent   u_d   d     q     rco
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 4'hE, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h5, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1};

    c_load_bar = 1'b1; c_enp_bar = 1'b1; c_ent_bar = 1'b0; c_u_d = 1'b1; c_d = 8'h00;

    // Reset with Cen high and counting enabled, then release with Cen still high.
    reset = 1'b1; cen = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    expect_val("reset_q", 0, 8'h00);
    expect_val("reset_rco", 1, 8'h01);
    drain();
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_val("no_trigger_after_release", 0, 8'h00);
    drain();
    pulse();
    expect_val("first_trigger", 0, 8'h01);
    drain();

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].load_bar, vecs[i].enp_bar, vecs[i].ent_bar, vecs[i].u_d, vecs[i].d);
      expect_val($sformatf("vec%0d_q", i), 0, {4'h0, vecs[i].exp_q});
      expect_val($sformatf("vec%0d_rco", i), 1, {7'h0, vecs[i].exp_rco});
      pulse();
      drain();
    end

    // Borrow at zero clears as soon as direction flips, with no clock.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    pulse();
    expect_val("zero_down_rco", 1, 8'h00);
    drain();
    @(negedge clk) u_d = 1'b1;
    #1;
    expect_val("zero_flip_up_rco", 1, 8'h01);
    drain();

    // Cen held high for several clocks: only the first edge counts.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    pulse();
    repeat (4) @(posedge clk);
    #1;
    expect_val("cen_held_one_trigger", 0, 8'h01);
    drain();

    // Cen toggling every clock: one count per two clocks.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) cen = ~cen;
    end
    @(posedge clk) #1;
    expect_val("cen_toggle_rate", 0, 8'h04);
    drain();

    // Async reset between posedges at Q=7.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'h7);
    pulse();
    expect_val("pre_reset_q7", 0, 8'h07);
    drain();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    @(negedge clk) #2 reset = 1'b1;
    #1;
    expect_val("async_reset_q", 0, 8'h00);
    drain();
    @(negedge clk) begin reset = 1'b0; cen = 1'b1; end
    @(posedge clk) #1;
    expect_val("cen_high_after_release", 0, 8'h00);
    drain();

    // Cascade: 8'h00 down -> 8'hFF, then up -> 8'h00.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    c_load_bar = 1'b0; c_enp_bar = 1'b0; c_u_d = 1'b0; c_d = 8'h00;
    pulse();
    expect_val("cascade_load", 2, 8'h00);
    drain();
    c_load_bar = 1'b1;
    pulse();
    expect_val("cascade_down", 2, 8'hFF);
    drain();
    c_u_d = 1'b1;
    pulse();
    expect_val("cascade_up", 2, 8'h00);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
